// File: rtl/addr_calc_pkg.sv
// Shared types and default widths for the address-calculation counters.
package addr_calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam int FS_W_DEF    = 32;
  localparam int SHIFT_W_DEF = 2;
  localparam int WRAP_W_DEF  = 8;

endpackage

// File: rtl/addr_filesize_counter_mc_if.sv
// Control/status bundle of the multi-channel filesize counter.
interface addr_filesize_counter_mc_if
  import addr_calc_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int FS_W    = FS_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int CNT_W   = FS_W + (1 << SHIFT_W) - 1,
  parameter int WRAP_W  = WRAP_W_DEF
);
  logic [NUM_CH-1:0]         enable;
  logic [NUM_CH-1:0]         pause;
  logic [NUM_CH-1:0]         wrap_mode;
  logic [NUM_CH*FS_W-1:0]    filesize;
  logic [NUM_CH*SHIFT_W-1:0] scale_shift;
  logic [NUM_CH*CNT_W-1:0]   count;
  logic [NUM_CH-1:0]         done;
  logic [NUM_CH-1:0]         done_pulse;
  logic [NUM_CH*WRAP_W-1:0]  wrap_cnt;
  logic                      all_done;

  modport master (
    output enable, pause, wrap_mode, filesize, scale_shift,
    input  count, done, done_pulse, wrap_cnt, all_done
  );

  modport slave (
    input  enable, pause, wrap_mode, filesize, scale_shift,
    output count, done, done_pulse, wrap_cnt, all_done
  );
endinterface

// File: rtl/addr_count_ch.sv
// One counter channel: IDLE/RUN/DONE FSM, target latch, count and wrap counter.
module addr_count_ch
  import addr_calc_pkg::*;
#(
  parameter int FS_W    = FS_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int CNT_W   = FS_W + (1 << SHIFT_W) - 1,
  parameter int WRAP_W  = WRAP_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pause,
  input  logic               wrap_mode,
  input  logic [FS_W-1:0]    filesize,
  input  logic [SHIFT_W-1:0] scale_shift,
  output logic [CNT_W-1:0]   count,
  output logic               done,
  output logic               done_pulse,
  output logic [WRAP_W-1:0]  wrap_cnt
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] target_q, count_q, new_target, count_nxt;
  logic             wrap_q, restart;

  // CNT_W leaves room for the largest shift, so the scaled target never truncates
  assign new_target = CNT_W'(filesize) << scale_shift;
  // in wrap mode count sits at target for one cycle, then restarts at 1
  assign restart    = wrap_q && (count_q == target_q);
  assign count_nxt  = restart ? CNT_W'(1) : count_q + 1'b1;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state; enable low wins over everything else
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = (new_target == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (!enable) state_d = ST_IDLE;
        else if (!pause && !wrap_q && count_nxt == target_q) state_d = ST_DONE;
      end
      ST_DONE: if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath: target latch, count, completion pulse, saturating pass counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q   <= '0;
      wrap_q     <= 1'b0;
      count_q    <= '0;
      done_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (!enable) begin
        count_q  <= '0;
        wrap_cnt <= '0;
      end else if (state_q == ST_IDLE) begin
        target_q   <= new_target;
        wrap_q     <= wrap_mode;
        count_q    <= '0;
        done_pulse <= (new_target == '0);
      end else if (state_q == ST_RUN && !pause) begin
        count_q    <= count_nxt;
        done_pulse <= (count_nxt == target_q);
        if (restart && wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
      end
    end
  end

  // outputs decoded from registered state
  always_comb begin
    count = count_q;
    done  = (state_q == ST_DONE);
  end

endmodule

// File: rtl/addr_filesize_counter_mc.sv
// Multi-channel filesize counter: NUM_CH independent channels plus all_done.
module addr_filesize_counter_mc
  import addr_calc_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int FS_W    = FS_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int CNT_W   = FS_W + (1 << SHIFT_W) - 1,
  parameter int WRAP_W  = WRAP_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  addr_filesize_counter_mc_if.slave  bus
);

  logic [NUM_CH-1:0][CNT_W-1:0]  count_w;
  logic [NUM_CH-1:0][WRAP_W-1:0] wrap_w;
  logic [NUM_CH-1:0]             done_w, pulse_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    addr_count_ch #(
      .FS_W(FS_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W), .WRAP_W(WRAP_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (bus.enable[c]),
      .pause       (bus.pause[c]),
      .wrap_mode   (bus.wrap_mode[c]),
      .filesize    (bus.filesize[c*FS_W +: FS_W]),
      .scale_shift (bus.scale_shift[c*SHIFT_W +: SHIFT_W]),
      .count       (count_w[c]),
      .done        (done_w[c]),
      .done_pulse  (pulse_w[c]),
      .wrap_cnt    (wrap_w[c])
    );
  end

  assign bus.count      = count_w;
  assign bus.wrap_cnt   = wrap_w;
  assign bus.done       = done_w;
  assign bus.done_pulse = pulse_w;

  // every enabled channel done, and at least one enabled
  always_comb begin
    bus.all_done = (|bus.enable) && (&(done_w | ~bus.enable));
  end

endmodule

// File: tb/tb_addr_filesize_counter_mc.sv
// Bench for addr_filesize_counter_mc: directed cases plus random traffic vs a model.
module tb_addr_filesize_counter_mc;
  import addr_calc_pkg::*;

  localparam int NUM_CH  = 2;
  localparam int FS_W    = 32;
  localparam int SHIFT_W = 2;
  localparam int CNT_W   = FS_W + (1 << SHIFT_W) - 1;
  localparam int WRAP_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addr_filesize_counter_mc_if #(
    .NUM_CH(NUM_CH), .FS_W(FS_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W), .WRAP_W(WRAP_W)
  ) bus ();

  addr_filesize_counter_mc #(
    .NUM_CH(NUM_CH), .FS_W(FS_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W), .WRAP_W(WRAP_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // model: a channel is described by how many unpaused cycles elapsed since its latch
  bit     m_act  [NUM_CH];
  bit     m_wrap [NUM_CH];
  bit     m_pulse[NUM_CH];
  longint m_tgt  [NUM_CH];
  longint m_el   [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint m_count(int c);
    if (!m_act[c] || m_tgt[c] == 0) return 0;
    if (m_wrap[c]) return (m_el[c] == 0) ? 0 : ((m_el[c] - 1) % m_tgt[c]) + 1;
    return (m_el[c] < m_tgt[c]) ? m_el[c] : m_tgt[c];
  endfunction

  function automatic bit m_done(int c);
    return m_act[c] && (m_tgt[c] == 0 || (!m_wrap[c] && m_el[c] >= m_tgt[c]));
  endfunction

  function automatic longint m_wcnt(int c);
    longint p;
    if (!m_act[c] || !m_wrap[c] || m_tgt[c] == 0 || m_el[c] == 0) return 0;
    p = (m_el[c] - 1) / m_tgt[c];
    return (p > 255) ? 255 : p;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 0; m_wrap[c] = 0; m_pulse[c] = 0; m_tgt[c] = 0; m_el[c] = 0;
    end
  endtask

  task automatic m_step();
    for (int c = 0; c < NUM_CH; c++) begin
      if (!bus.enable[c]) begin
        m_act[c] = 0; m_el[c] = 0; m_pulse[c] = 0;
      end else if (!m_act[c]) begin
        m_act[c]   = 1;
        m_tgt[c]   = longint'(bus.filesize[c*FS_W +: FS_W]) << bus.scale_shift[c*SHIFT_W +: SHIFT_W];
        m_wrap[c]  = bus.wrap_mode[c];
        m_el[c]    = 0;
        m_pulse[c] = (m_tgt[c] == 0);
      end else begin
        m_pulse[c] = 0;
        if (m_tgt[c] != 0 && !m_done(c) && !bus.pause[c]) begin
          m_el[c]++;
          m_pulse[c] = (m_count(c) == m_tgt[c]);
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    bit ad;
    ad = |bus.enable;
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("%s_count%0d", ph, c), 64'(bus.count[c*CNT_W +: CNT_W]), m_count(c));
      chk($sformatf("%s_done%0d", ph, c), 64'(bus.done[c]), 64'(m_done(c)));
      chk($sformatf("%s_pulse%0d", ph, c), 64'(bus.done_pulse[c]), 64'(m_pulse[c]));
      chk($sformatf("%s_wrap%0d", ph, c), 64'(bus.wrap_cnt[c*WRAP_W +: WRAP_W]), m_wcnt(c));
      if (bus.enable[c] && !m_done(c)) ad = 0;
    end
    chk({ph, "_all_done"}, 64'(bus.all_done), 64'(ad));
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic cyc(input string ph);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic set_ch(input int c, input bit e, input bit p, input bit w,
                        input logic [FS_W-1:0] f, input logic [SHIFT_W-1:0] s);
    bus.enable[c] = e;
    bus.pause[c] = p;
    bus.wrap_mode[c] = w;
    bus.filesize[c*FS_W +: FS_W] = f;
    bus.scale_shift[c*SHIFT_W +: SHIFT_W] = s;
  endtask

  task automatic idle_all();
    bus.enable = '0;
    bus.pause = '0;
    cyc("idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_pulse;
    int npulse;
    longint big_t;

    bus.enable = '0; bus.pause = '0; bus.wrap_mode = '0;
    bus.filesize = '0; bus.scale_shift = '0;
    m_reset();
    #12;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-run: target 10, stop at count 4, async reset clears at once
    set_ch(0, 1, 0, 0, 5, 1);
    for (int k = 0; k < 5; k++) cyc("mid");
    chk("mid_pre_count", 64'(bus.count[CNT_W-1:0]), 4);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_async_count", 64'(bus.count[CNT_W-1:0]), 0);
    chk("rst_async_done", 64'(bus.done[0]), 0);
    bus.enable = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst");

    // single-shot, target 6
    set_ch(0, 1, 0, 0, 3, 1);
    for (int k = 0; k <= 6; k++) cyc("ss");
    chk("ss_count6", 64'(bus.count[CNT_W-1:0]), 6);
    chk("ss_pulse", 64'(bus.done_pulse[0]), 1);
    for (int k = 0; k < 10; k++) cyc("ss_hold");
    chk("ss_hold_count", 64'(bus.count[CNT_W-1:0]), 6);
    chk("ss_hold_done", 64'(bus.done[0]), 1);
    chk("ss_all_done", 64'(bus.all_done), 1);
    idle_all();

    // pause three cycles at count 2, target 4: pulse at E+7
    set_ch(0, 1, 0, 0, 4, 0);
    k_pulse = -1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) bus.pause[0] = 1'b1;
      if (k == 6) bus.pause[0] = 1'b0;
      cyc("pause");
      if (k == 5) chk("pause_hold", 64'(bus.count[CNT_W-1:0]), 2);
      if (bus.done_pulse[0] && k_pulse < 0) k_pulse = k;
    end
    chk("pause_latency", 64'(k_pulse), 7);
    idle_all();

    // wrap, target 4, 300 passes
    set_ch(0, 1, 0, 1, 2, 1);
    npulse = 0;
    for (int k = 0; k <= 1200; k++) begin
      cyc("wrap");
      if (bus.done_pulse[0]) npulse++;
    end
    chk("wrap_pulses", 64'(npulse), 300);
    chk("wrap_sat", 64'(bus.wrap_cnt[WRAP_W-1:0]), 255);
    chk("wrap_done", 64'(bus.done[0]), 0);
    idle_all();

    // zero target, also with wrap requested
    set_ch(0, 1, 0, 1, 0, 2);
    cyc("zero");
    chk("zero_done", 64'(bus.done[0]), 1);
    chk("zero_pulse", 64'(bus.done_pulse[0]), 1);
    chk("zero_count", 64'(bus.count[CNT_W-1:0]), 0);
    cyc("zero");
    idle_all();

    // maximum target, jump close to it and let it finish
    set_ch(0, 1, 0, 0, 32'hFFFF_FFFF, 2'd3);
    cyc("big");
    big_t = 64'h7_FFFF_FFF8;
    chk("big_target", 64'(dut.g_ch[0].u_ch.target_q), big_t);
    force dut.g_ch[0].u_ch.count_q = CNT_W'(big_t - 3);
    m_el[0] = big_t - 3;
    #1;
    release dut.g_ch[0].u_ch.count_q;
    for (int k = 0; k < 3; k++) cyc("big");
    chk("big_count", 64'(bus.count[CNT_W-1:0]), big_t);
    chk("big_pulse", 64'(bus.done_pulse[0]), 1);
    idle_all();

    // independence and abort
    set_ch(0, 1, 0, 0, 4, 0);
    set_ch(1, 1, 0, 0, 10, 0);
    for (int k = 0; k <= 5; k++) cyc("ind");
    chk("ind_ch1_5", 64'(bus.count[CNT_W +: CNT_W]), 5);
    bus.enable[1] = 1'b0;
    cyc("ind_abort");
    chk("ind_ch1_zero", 64'(bus.count[CNT_W +: CNT_W]), 0);
    chk("ind_ch0_held", 64'(bus.count[CNT_W-1:0]), 4);
    chk("ind_all_done", 64'(bus.all_done), 1);
    idle_all();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.enable[c]) begin
          if ($urandom_range(15) == 0) bus.enable[c] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          bus.enable[c] = 1'b1;
        end
        bus.pause[c] = ($urandom_range(3) == 0);
        if ($urandom_range(3) == 0) begin
          bus.wrap_mode[c] = 1'($urandom_range(1));
          bus.filesize[c*FS_W +: FS_W] = FS_W'($urandom_range(7));
          bus.scale_shift[c*SHIFT_W +: SHIFT_W] = SHIFT_W'($urandom_range(3));
        end
      end
      cyc("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_filesize_counter_mc.md
# addr_filesize_counter_mc

Multi-channel, parametrised filesize counter for the address-calculation top. It generalises the fixed per-accelerator counters (1x1 word filters, FFT output at 2x filesize) into one block. Each channel counts from 1 up to a run-time target of filesize scaled by a per-channel power-of-two word multiplier, with pause, single-shot or wrap mode, and done level/pulse outputs. It feeds the per-accelerator address generators and the router's completion logic.

## Interface
Parameters:
- NUM_CH, 2, number of independent counter channels
- FS_W, 32, filesize width
- SHIFT_W, 2, width of per-channel scale shift (multiplier 1..8)
- CNT_W, FS_W+(1<<SHIFT_W)-1, count width, sized so the scaled target never truncates
- WRAP_W, 8, width of the per-channel saturating wrap counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  NUM_CH  per-channel run enable; low forces channel idle
- pause  in  NUM_CH  per-channel hold; freezes count while high
- wrap_mode  in  NUM_CH  1 = restart at 1 after reaching target, 0 = single-shot
- filesize  in  NUM_CH*FS_W  per-channel filesize, channel c at [c*FS_W +: FS_W]
- scale_shift  in  NUM_CH*SHIFT_W  target = filesize << scale_shift
- count  out  NUM_CH*CNT_W  per-channel current count
- done  out  NUM_CH  level; high while channel holds at target (single-shot)
- done_pulse  out  NUM_CH  one-cycle pulse each time count reaches target
- wrap_cnt  out  NUM_CH*WRAP_W  completed passes, saturates at all-ones
- all_done  out  1  high when every enabled channel has done=1 and at least one channel is enabled

## Operation
- Per-channel FSM: IDLE, RUN, DONE.
- IDLE: count=0, done=0, wrap_cnt=0. On enable=1, latch target=filesize<<scale_shift and wrap_mode, then go to RUN. If target==0, go to DONE instead with done=1 and done_pulse=1.
- RUN: if pause=0, count<=count+1. When count+1==target, count<=target and done_pulse=1 on that edge. Single-shot: go to DONE with done=1. Wrap mode: stay in RUN. The next unpaused cycle count<=1, and wrap_cnt increments, saturating.
- RUN with pause=1: count, state and outputs hold. done_pulse=0.
- DONE: count holds at target, done=1. Exit only via enable=0.
- enable=0 in any state: next edge goes to IDLE, count=0, done=0, done_pulse=0, wrap_cnt=0. This takes priority over pause.
- filesize, scale_shift and wrap_mode changes after the latch are ignored until the channel returns to IDLE.
- Wrap mode with target==0: treated as single-shot DONE.
- Channels are fully independent. all_done is combinational from done and enable.

## Timing
- Reset (rst_n=0, asynchronous): all channels IDLE. count=0, done=0, done_pulse=0, wrap_cnt=0, all_done=0.
- Enable sampled high at edge E: RUN with count=0 after E. count=1 after E+1. With no pauses, count=target and done_pulse=1 after edge E+target.
- Each paused cycle delays completion by exactly one cycle.
- Wrap mode: count reaches target every `target` unpaused cycles (sequence 1..target, 1..target).
- enable=0 at edge X: idle values are visible after X. Re-enable needs at least one cycle low.
- count, done, done_pulse and wrap_cnt are registered. all_done adds no register stage.

## Structure
- Shared package addr_calc_pkg holds:
  - state typedef (IDLE/RUN/DONE)
  - default width constants FS_W_DEF, SHIFT_W_DEF, WRAP_W_DEF
- Sub-module addr_count_ch implements one channel: FSM, target latch, count, wrap counter.
- The top generate-loops NUM_CH instances, slices the flattened buses and forms all_done.

## Test plan
- Reset mid-run: ch0 filesize=5, shift=1, running at count=4; assert rst_n=0 -> count=0, done=0 immediately, before the next clk edge.
- Single-shot: filesize=3, shift=1, pause=0 -> count 0,1..6. done_pulse=1 on the edge count becomes 6. done stays 1 and count stays 6 for 10 cycles. all_done=1.
- Pause: filesize=4, shift=0, pause high for 3 cycles at count=2 -> count holds at 2. done_pulse arrives 3 cycles later than the unpaused case, at E+7.
- Wrap: filesize=2, shift=1, wrap_mode=1, 300 passes -> count cycles 1..4, done_pulse every 4 cycles, wrap_cnt saturates at 255, done stays 0.
- Edge targets:
  - filesize=0 -> done=1 one cycle after enable, count=0.
  - filesize=0xFFFFFFFF, shift=3 -> target=0x7FFFFFFF8, no truncation; force-check the near-target boundary.
- Independence and abort: ch0 single-shot target 4, ch1 target 10. Drop ch1 enable at count=5 -> ch1 count=0 next cycle, ch0 unaffected. all_done=1 once ch0 is done and ch1 is disabled.
